// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: RV32I branch funct3 codes,
// the branch ALU op and the 2-bit predictor counter states.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ALUOP_BRANCH = 2'b01;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RESET = WNT;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between decode/execute, the front end and the branch resolve unit.
// master = requester/front end, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic [XLEN-1:0]  lookup_pc_i;
  logic             predict_taken_o;
  logic             valid_i;
  logic             branch_i;
  logic [1:0]       aluop_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  target_i;
  logic             pred_taken_i;
  logic             out_valid_o;
  logic             taken_o;
  logic             mispredict_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             illegal_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output lookup_pc_i, valid_i, branch_i, aluop_i, funct3_i,
           rs1_i, rs2_i, pc_i, target_i, pred_taken_i,
    input  predict_taken_o, out_valid_o, taken_o, mispredict_o,
           redirect_pc_o, illegal_o, branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  lookup_pc_i, valid_i, branch_i, aluop_i, funct3_i,
           rs1_i, rs2_i, pc_i, target_i, pred_taken_i,
    output predict_taken_o, out_valid_o, taken_o, mispredict_o,
           redirect_pc_o, illegal_o, branch_cnt_o, mispred_cnt_o
  );

endinterface

// File: rtl/branch_resolve_unit_sat_counter2.sv
// 2-bit saturating up/down counter (SNT <-> WNT <-> WT <-> ST) used as one
// branch history table entry.
module sat_counter2
  import branch_pkg::*;
#(
  parameter logic [1:0] INIT = BHT_RESET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       dir_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // next count: step toward the taken/not-taken extreme, clamp at the ends
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (dir_i) begin
        if (cnt_q != ST) begin
          cnt_d = cnt_q + 2'b01;
        end else begin
          cnt_d = ST;
        end
      end else begin
        if (cnt_q != SNT) begin
          cnt_d = cnt_q - 2'b01;
        end else begin
          cnt_d = SNT;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches in one cycle, flags mispredictions,
// trains a PC-indexed 2-bit BHT and keeps saturating branch statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  logic                      req_s;
  logic                      legal_s;
  logic                      cond_s;
  logic                      eq_s;
  logic                      lts_s;
  logic                      ltu_s;
  logic                      bht_en_s;
  logic [XLEN-1:0]           pc_next_s;
  logic [IDX_BITS-1:0]       upd_idx_s;
  logic [IDX_BITS-1:0]       look_idx_s;
  logic [DEPTH-1:0][1:0]     bht_s;
  logic                      unused_lookup_s;

  logic                      out_valid_q, out_valid_d;
  logic                      taken_q, taken_d;
  logic                      mispredict_q, mispredict_d;
  logic                      illegal_q, illegal_d;
  logic [XLEN-1:0]           redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]          branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]          mispred_cnt_q, mispred_cnt_d;

  assign req_s      = bus.valid_i && bus.branch_i && (bus.aluop_i == ALUOP_BRANCH);
  assign eq_s       = (bus.rs1_i == bus.rs2_i);
  assign lts_s      = ($signed(bus.rs1_i) < $signed(bus.rs2_i));
  assign ltu_s      = (bus.rs1_i < bus.rs2_i);
  assign pc_next_s  = bus.pc_i + PC_STEP;
  assign upd_idx_s  = bus.pc_i[IDX_BITS+1:2];
  assign look_idx_s = bus.lookup_pc_i[IDX_BITS+1:2];
  assign bht_en_s   = req_s && legal_s;

  // Only the index bits of the lookup PC matter; aliasing above them is accepted.
  assign unused_lookup_s = ^{bus.lookup_pc_i[XLEN-1:IDX_BITS+2], bus.lookup_pc_i[1:0]};

  // branch condition select; 010/011 are not branch encodings
  always_comb begin
    cond_s  = 1'b0;
    legal_s = 1'b1;
    case (bus.funct3_i)
      F3_BEQ:  cond_s = eq_s;
      F3_BNE:  cond_s = !eq_s;
      F3_BLT:  cond_s = lts_s;
      F3_BGE:  cond_s = !lts_s;
      F3_BLTU: cond_s = ltu_s;
      F3_BGEU: cond_s = !ltu_s;
      default: begin
        cond_s  = 1'b0;
        legal_s = 1'b0;
      end
    endcase
  end

  // result and statistics next-state
  always_comb begin
    out_valid_d   = 1'b0;
    taken_d       = taken_q;
    mispredict_d  = 1'b0;
    illegal_d     = 1'b0;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (req_s) begin
      out_valid_d = 1'b1;
      if (legal_s) begin
        taken_d       = cond_s;
        mispredict_d  = cond_s ^ bus.pred_taken_i;
        redirect_pc_d = cond_s ? bus.target_i : pc_next_s;
        if (branch_cnt_q != CNT_MAX) begin
          branch_cnt_d = branch_cnt_q + CNT_ONE;
        end else begin
          branch_cnt_d = CNT_MAX;
        end
        if (mispredict_d && (mispred_cnt_q != CNT_MAX)) begin
          mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end else begin
          mispred_cnt_d = mispred_cnt_q;
        end
      end else begin
        taken_d       = 1'b0;
        illegal_d     = 1'b1;
        redirect_pc_d = pc_next_s;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // output and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= {XLEN{1'b0}};
      branch_cnt_q  <= {CNT_W{1'b0}};
      mispred_cnt_q <= {CNT_W{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      illegal_q     <= illegal_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_bht
    sat_counter2 #(
      .INIT (BHT_RESET)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .en_i  (bht_en_s && (upd_idx_s == IDX_BITS'(i))),
      .dir_i (cond_s),
      .cnt_o (bht_s[i])
    );
  end

  // Read is from the registered table, so a same-cycle update is not bypassed.
  assign bus.predict_taken_o = bht_s[look_idx_s][1];
  assign bus.out_valid_o     = out_valid_q;
  assign bus.taken_o         = taken_q;
  assign bus.mispredict_o    = mispredict_q;
  assign bus.illegal_o       = illegal_q;
  assign bus.redirect_pc_o   = redirect_pc_q;
  assign bus.branch_cnt_o    = branch_cnt_q;
  assign bus.mispred_cnt_o   = mispred_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch decision logic.
- Does its own XLEN-wide signed/unsigned compare for all six RV32I branch conditions, instead of taking precomputed zero/less-than flags.
- Registers the resolved outcome and flags mispredictions against a prediction supplied by the front end.
- Keeps a PC-indexed table of 2-bit saturating counters (BHT) and saturating statistics counters. Sits between decode/execute and the PC-select mux.

Parameters:
- XLEN, 32, operand/PC width.
- IDX_BITS, 6, BHT index width; table depth = 2**IDX_BITS entries.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- lookup_pc_i  in  XLEN  fetch PC for prediction lookup.
- predict_taken_o  out  1  combinational prediction = MSB of BHT[lookup_pc_i[IDX_BITS+1:2]].
- valid_i  in  1  resolve request present this cycle.
- branch_i  in  1  control-unit branch flag.
- aluop_i  in  2  ALU op; 2'b01 = branch class.
- funct3_i  in  3  branch condition.
- rs1_i, rs2_i  in  XLEN each  compare operands.
- pc_i  in  XLEN  PC of the branch instruction.
- target_i  in  XLEN  precomputed branch target.
- pred_taken_i  in  1  prediction the front end used for this branch.
- out_valid_o  out  1  registered: resolved branch result valid.
- taken_o  out  1  registered outcome.
- mispredict_o  out  1  registered; taken_o != prediction used.
- redirect_pc_o  out  XLEN  registered; target_i if taken, else pc_i+4 (mod 2**XLEN).
- illegal_o  out  1  registered; funct3 010/011 seen on a branch-class request.
- branch_cnt_o  out  CNT_W  resolved-branch count, saturating.
- mispred_cnt_o  out  CNT_W  misprediction count, saturating.

Behaviour:
- Qualify: req = valid_i && branch_i && (aluop_i == 2'b01). When req is low:
  - out_valid_o, illegal_o, mispredict_o go to 0 next cycle.
  - taken_o and redirect_pc_o hold their values.
  - No BHT or counter update.
- Condition select (combinational):
  - 000 BEQ: rs1 == rs2.
  - 001 BNE: rs1 != rs2.
  - 100 BLT: signed <.
  - 101 BGE: signed >=.
  - 110 BLTU: unsigned <.
  - 111 BGEU: unsigned >=.
  - 010/011 are illegal.
- Latency: exactly 1 cycle. Outputs update on the clk edge after a req cycle. Back-to-back reqs are accepted every cycle with no stall.
- Legal req, at the edge:
  - out_valid_o=1, taken_o=cond.
  - mispredict_o = cond ^ pred_taken_i.
  - redirect_pc_o per port definition, illegal_o=0.
  - BHT[pc_i[IDX_BITS+1:2]]: increment if taken, else decrement, saturating at 2'b11 / 2'b00.
  - branch_cnt_o += 1.
  - mispred_cnt_o += 1 if mispredict.
- Illegal req, at the edge:
  - out_valid_o=1, illegal_o=1, taken_o=0, mispredict_o=0.
  - redirect_pc_o = pc_i+4.
  - No BHT update, no counter increments.
- Statistics counters saturate at all-ones and never wrap.
- Simultaneous lookup and update of the same BHT index: predict_taken_o shows the pre-update value in that cycle and the new value from the next cycle (no bypass).
- PC bits [1:0] are ignored for indexing. PCs differing only above bit IDX_BITS+1 alias to the same entry; this is accepted.
- Reset, synchronous, dominates any req in the same cycle:
  - out_valid_o, taken_o, mispredict_o, illegal_o = 0; redirect_pc_o = 0.
  - Both stats counters = 0.
  - Every BHT entry = 2'b01 (weakly not-taken), so predict_taken_o reads 0 after reset.
- Reset asserted mid-stream discards the in-flight result. The first req after reset deassertion behaves as on a fresh table.
- No internal FSM beyond the BHT counters. Each entry follows the transitions SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).

Decomposition:
- Shared package branch_pkg holds:
  - funct3 constants F3_BEQ..F3_BGEU.
  - ALUOP_BRANCH = 2'b01.
  - 2-bit counter localparams SNT/WNT/WT/ST and BHT_RESET = WNT.
- One natural sub-module, sat_counter2: 2-bit saturating up/down counter with en, dir and synchronous reset to a parameterised init value. Instantiate it 2**IDX_BITS times in a generate loop.
- Compare and select logic stays inline.

Test Plan:
- Reset, then lookup_pc_i=0x40 -> predict_taken_o=0. Counters 0 and out_valid_o=0 one cycle after reset.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken_i=0, pc=0x100, target=0x80 -> next cycle taken_o=1, mispredict_o=1, redirect_pc_o=0x80, mispred_cnt_o=1. Same operands with BLTU -> taken_o=0, redirect_pc_o=0x104.
- Three taken BEQs at pc=0x200 (rs1=rs2=5) -> entry 0 walks 01->10->11->11 (saturates). predict_taken_o at lookup 0x200 = 1 after the first one. Lookup in the same cycle as the first update still returns 0.
- funct3=010 with valid_i=1, branch_i=1, aluop_i=01, pc=0x300 -> illegal_o=1, out_valid_o=1, taken_o=0, redirect_pc_o=0x304, branch_cnt_o unchanged.
- branch_i=1 with aluop_i=00, or valid_i=0 -> out_valid_o=0, no BHT or counter change. Preload branch_cnt_o to all-ones via CNT_W=2 plus 3 branches, then a 4th -> stays 2'b11.
- Assert reset in the same cycle as a legal taken req -> reset wins. All outputs 0 next cycle, BHT entry for that PC reads WNT, branch_cnt_o=0.
